// File: rtl/rr_arbiter32.sv
// 32-way round-robin arbiter driving the select of a 32-to-1 mux; one owner at a time, registered outputs.
// Define RR_ARB_TIMEOUT_EN to revoke grants held for TIMEOUT_CYCLES cycles while other requesters wait.
module rr_arbiter32 #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    output logic [31:0] gnt,
    output logic [4:0]  sel,
    output logic        busy,
    output logic        rel,
    output logic        tmo
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter32: TIMEOUT_CYCLES must be within 2..255");
    end

    logic [0:0]  state, state_n;
    logic [4:0]  ptr, ptr_n;
    logic [31:0] gnt_n;
    logic [4:0]  sel_n;
    logic        busy_n;
    logic        rel_n;
    logic [5:0]  pick;
    logic        do_grant;
    logic        do_rearb;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt, cnt_n;
    logic       tmo_n;
`endif

    // Returns {found, index}: first set bit of r scanning upward from start, wrapping 31 -> 0.
    function automatic logic [5:0] rr_pick(input logic [31:0] r, input logic [4:0] start);
        logic       found;
        logic [4:0] idx;
        logic [4:0] win;
        found = 1'b0;
        win   = start;
        for (int i = 0; i < 32; i++) begin
            idx = start + 5'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        state_n  = state;
        ptr_n    = ptr;
        gnt_n    = gnt;
        sel_n    = sel;
        busy_n   = busy;
        rel_n    = 1'b0;
        do_grant = 1'b0;
        do_rearb = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        tmo_n    = 1'b0;
        cnt_n    = cnt;
`endif
        // While granted, the current owner is masked so a re-arbitration never hands it straight back.
        pick = rr_pick((state == ST_GRANT) ? (req & ~gnt) : req, ptr);

        if (state == ST_IDLE) begin
            do_grant = pick[5];
        end else if (~|(req & gnt)) begin
            rel_n    = 1'b1;
            do_rearb = 1'b1;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (cnt == TMO_LAST) begin
            if (pick[5]) begin
                rel_n    = 1'b1;
                tmo_n    = 1'b1;
                do_rearb = 1'b1;
            end else begin
                cnt_n = '0;
            end
        end else begin
            cnt_n = cnt + 8'd1;
        end
`endif

        if (do_rearb) begin
            if (pick[5]) begin
                do_grant = 1'b1;
            end else begin
                state_n = ST_IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        end

        if (do_grant) begin
            state_n = ST_GRANT;
            gnt_n   = 32'd1 << pick[4:0];
            sel_n   = pick[4:0];
            busy_n  = 1'b1;
            ptr_n   = pick[4:0] + 5'd1;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_n   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            rel   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state <= state_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            busy  <= busy_n;
            rel   <= rel_n;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            cnt <= cnt_n;
            tmo <= tmo_n;
        end
    end
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32: reset, round-robin order, wrap, release, async reset and grant timeout.
module tb_rr_arbiter32;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic [31:0] gnt;
    logic [4:0]  sel;
    logic        busy;
    logic        rel;
    logic        tmo;

    logic [39:0] obs;
    logic [39:0] exp;
    int          checks;
    int          errors;

    assign obs = {gnt, sel, busy, rel, tmo};

    rr_arbiter32 #(.TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .rel  (rel),
        .tmo  (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req   = '0;
        #1 rst_n = 1'b0;
        #2;
        exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_async: got %h want %h", obs, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = '0; checks++;
            if (obs !== exp) begin errors++; $display("FAIL idle_no_req[%0d]: got %h want %h", i, obs, exp); end
        end
    endtask

    // ptr=0 at entry; leaves ptr=3.
    task automatic test_basic();
        req = 32'h5; tick();
        exp = {32'h1, 5'd0, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL basic_grant0: got %h want %h", obs, exp); end
        req = 32'h7; tick();
        exp = {32'h1, 5'd0, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL basic_hold_other_req: got %h want %h", obs, exp); end
        req = 32'h4; tick();
        exp = {32'h4, 5'd2, 3'b110}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL basic_release_move: got %h want %h", obs, exp); end
        tick();
        exp = {32'h4, 5'd2, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL basic_rel_one_cycle: got %h want %h", obs, exp); end
        req = 32'h0; tick();
        exp = {32'h0, 5'd2, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL basic_release_idle: got %h want %h", obs, exp); end
        tick();
        exp = {32'h0, 5'd2, 3'b000}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL basic_idle_sel_kept: got %h want %h", obs, exp); end
    endtask

    // ptr=3 at entry; leaves ptr=2.
    task automatic test_priority();
        req = 32'hB; tick();
        exp = {32'h8, 5'd3, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL prio_from_ptr3: got %h want %h", obs, exp); end
        req = 32'h3; tick();
        exp = {32'h1, 5'd0, 3'b110}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL prio_wrap_to0: got %h want %h", obs, exp); end
        req = 32'h2; tick();
        exp = {32'h2, 5'd1, 3'b110}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL prio_next1: got %h want %h", obs, exp); end
        req = 32'h0; tick();
        exp = {32'h0, 5'd1, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL prio_idle: got %h want %h", obs, exp); end
    endtask

    // ptr=2 at entry; leaves ptr=1.
    task automatic test_wrap();
        req = 32'h4000_0000; tick();
        exp = {32'h4000_0000, 5'd30, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_grant30: got %h want %h", obs, exp); end
        req = 32'h0; tick();
        exp = {32'h0, 5'd30, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_release30: got %h want %h", obs, exp); end
        req = 32'h8000_0001; tick();
        exp = {32'h8000_0000, 5'd31, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_grant31: got %h want %h", obs, exp); end
        req = 32'h1; tick();
        exp = {32'h1, 5'd0, 3'b110}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_31_to_0: got %h want %h", obs, exp); end
        req = 32'h0; tick();
        exp = {32'h0, 5'd0, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_idle: got %h want %h", obs, exp); end
    endtask

    // ptr=1 at entry; leaves ptr=9.
    task automatic test_single();
        req = 32'h100; tick();
        exp = {32'h100, 5'd8, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_grant8: got %h want %h", obs, exp); end
        req = 32'h0; tick();
        exp = {32'h0, 5'd8, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_release: got %h want %h", obs, exp); end
        tick();
        exp = {32'h0, 5'd8, 3'b000}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_sel_kept: got %h want %h", obs, exp); end
        req = 32'h100; tick();
        exp = {32'h100, 5'd8, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_regrant: got %h want %h", obs, exp); end
        req = 32'h500; tick();
        exp = {32'h100, 5'd8, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_hold: got %h want %h", obs, exp); end
        req = 32'h400; tick();
        exp = {32'h400, 5'd10, 3'b110}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_move10: got %h want %h", obs, exp); end
        req = 32'h500; tick();
        exp = {32'h400, 5'd10, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_reraise_no_steal: got %h want %h", obs, exp); end
        req = 32'h100; tick();
        exp = {32'h100, 5'd8, 3'b110}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_back_to8: got %h want %h", obs, exp); end
        req = 32'h0; tick();
        exp = {32'h0, 5'd8, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL single_final_idle: got %h want %h", obs, exp); end
    endtask

    // Leaves ptr=18.
    task automatic test_reset_mid_grant();
        req = 32'h0002_0000; tick();
        exp = {32'h0002_0000, 5'd17, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_grant17: got %h want %h", obs, exp); end
        req = 32'h0002_0008;
        #2 rst_n = 1'b0;
        #1;
        exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_async_clear: got %h want %h", obs, exp); end
        tick();
        exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_no_rel: got %h want %h", obs, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp = {32'h8, 5'd3, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_search_from0: got %h want %h", obs, exp); end
        req = 32'h0002_0000; tick();
        exp = {32'h0002_0000, 5'd17, 3'b110}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_then17: got %h want %h", obs, exp); end
        req = 32'h0; tick();
        exp = {32'h0, 5'd17, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_idle: got %h want %h", obs, exp); end
    endtask

    task automatic test_timeout();
        req = 32'h3; tick();
        exp = {32'h1, 5'd0, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL tmo_grant0: got %h want %h", obs, exp); end
        for (int i = 1; i <= 16; i++) begin
            tick();
`ifdef RR_ARB_TIMEOUT_EN
            exp = (i == 16) ? {32'h2, 5'd1, 3'b111} : {32'h1, 5'd0, 3'b100};
`else
            exp = {32'h1, 5'd0, 3'b100};
`endif
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL tmo_hold[%0d]: got %h want %h", i, obs, exp); end
        end
`ifdef RR_ARB_TIMEOUT_EN
        req = 32'h2;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = {32'h2, 5'd1, 3'b100}; checks++;
            if (obs !== exp) begin errors++; $display("FAIL tmo_alone_kept[%0d]: got %h want %h", i, obs, exp); end
        end
        req = 32'h0; tick();
        exp = {32'h0, 5'd1, 3'b010}; checks++;
`else
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = {32'h1, 5'd0, 3'b100}; checks++;
            if (obs !== exp) begin errors++; $display("FAIL tmo_disabled_hold[%0d]: got %h want %h", i, obs, exp); end
        end
        req = 32'h0; tick();
        exp = {32'h0, 5'd0, 3'b010}; checks++;
`endif
        if (obs !== exp) begin errors++; $display("FAIL tmo_release: got %h want %h", obs, exp); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_priority();
        test_wrap();
        test_single();
        test_reset_mid_grant();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter32.md
RR_ARBITER32 -- requirements
Module: rr_arbiter32

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, range 2..255: maximum grant length in cycles when RR_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  32  request lines; bit i = requester i, level-sensitive, held until done.
REQ-005 gnt  output  32  one-hot grant to requester i; all-zero when idle.
REQ-006 sel  output  5  binary index of granted requester; drives S of the 32-to-1 mux.
REQ-007 busy  output  1  high while any grant is active.
REQ-008 rel  output  1  one-cycle pulse when a grant ends, by release or timeout.
REQ-009 tmo  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 Two states: IDLE (no grant) and GRANT (one requester owns the mux); all outputs registered.
REQ-011 Round-robin pointer ptr (5 bits): search starts at ptr and ascends with wrap 31->0; the first set req bit wins.
REQ-012 IDLE -> GRANT: edge where req != 0; winner k drives gnt[k]=1, sel=k, busy=1 after that edge (latency 1 cycle).
REQ-013 On each new grant to k, ptr <= (k+1) mod 32; k=31 gives ptr=0.
REQ-014 In GRANT: gnt, sel and busy hold while req[k]=1; changes on other req bits do not affect the current grant.
REQ-015 Release: edge sampling req[k]=0 pulses rel=1 for one cycle and re-arbitrates in the same edge over req with bit k masked.
REQ-016 Re-arbitration with a winner j: GRANT stays, gnt moves directly k->j with no idle cycle; ptr <= j+1.
REQ-017 Re-arbitration with no winner: state -> IDLE, gnt=0, busy=0; sel keeps its last value.
REQ-018 gnt always has at most one bit set; gnt[sel]=1 whenever busy=1.
REQ-019 Simultaneous requests: only ptr order decides; lowest index at or above ptr wins, with wrap.
REQ-020 A requester dropping and re-raising req in consecutive cycles is not re-granted before higher-priority pending requesters (masked per REQ-015).

Reset
REQ-021 rst_n=0 immediately clears: state=IDLE, gnt=0, sel=0, busy=0, rel=0, tmo=0, ptr=0, timeout counter=0.
REQ-022 Reset during GRANT aborts the grant with no rel pulse; the first arbitration after rst_n rises starts from ptr=0.

Configuration
REQ-023 Macro RR_ARB_TIMEOUT_EN selects the grant-timeout feature.
REQ-024 Defined: counter clears on each new grant and increments each GRANT cycle; at TIMEOUT_CYCLES cycles with other req bits pending, that edge pulses tmo=1 and rel=1 and re-arbitrates with k masked (REQ-015/016).
REQ-025 Defined, no other request pending at timeout: grant kept, counter restarts at 0, no tmo pulse.
REQ-026 Not defined: no counter is present, grants last until release, and tmo is tied 0.

Verification
REQ-027 Reset, req=0x0000_0000 -> gnt=0, sel=0, busy=0 indefinitely.
REQ-028 req=0x0000_0005 from ptr=0 -> gnt=0x1, sel=0; req[0] drops -> rel pulse, next cycle gnt=0x4, sel=2, ptr=3.
REQ-029 ptr=31, req=0x8000_0001 -> gnt=0x8000_0000, sel=31; release -> gnt=0x1, sel=0 (wrap).
REQ-030 Single requester req=0x0000_0100 released -> rel pulse, busy=0, sel stays 8; re-raised -> granted again, ptr=9.
REQ-031 rst_n pulsed low mid-grant (sel=17) -> gnt=0 asynchronously, no rel; next grant searches from 0.
REQ-032 RR_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, req=0x3 held -> grant 0 for 16 cycles, tmo+rel pulse, then gnt=0x2, sel=1; without macro, grant 0 holds and tmo stays 0.
